uart_status_transmitter: RTL and testbench

UART_STATUS_TRANSMITTER -- requirements
Module: uart_status_transmitter

---
 rtl/uart_status_transmitter.sv | 160 ++++++++++++++++
 tb/tb_uart_status_transmitter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_status_transmitter.sv
// uart_status_transmitter: 8-bit UART transmitter with a one-entry holding buffer.
// A byte written while a frame is in flight waits in the buffer. It starts as soon
// as the current stop bit ends, with no idle bit between the two frames.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit (8E1, 11-bit frame).
// Without the macro the frame is 8N1 (10 bits).
// CLKS_PER_BIT must be 2 or larger.
//
// state  | meaning
// IDLE   | line high, waiting for the buffer to fill
// START  | driving the start bit (low)
// DATA   | driving data bits LSB first, bit_idx selects the bit
// PARITY | driving the even-parity bit (only with UART_TX_PARITY_EN)
// STOP   | driving the stop bit (high); chains into START if the buffer is full
module uart_status_transmitter #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_out,
  output logic       busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  logic [2:0]        state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [2:0]        bit_idx_inc;
  logic [7:0]        shift_reg;
  logic [7:0]        buf_data;
  logic              buf_full;
  logic              buf_full_nxt;
  logic              accept;
  logic              load;
  logic              baud_last;

  // Buffer handshake. tx_ready is low on any edge where load can fire, so accept
  // and load are mutually exclusive.
  assign accept       = tx_valid && tx_ready;
  assign baud_last    = (baud_cnt == BAUD_LAST);
  assign load         = buf_full && ((state == IDLE) || ((state == STOP) && baud_last));
  assign buf_full_nxt = accept || (buf_full && !load);
  assign bit_idx_inc  = bit_idx + 3'd1;
  assign busy         = (state != IDLE) || buf_full;

  // Holding buffer: captures tx_data on accept; tx_ready mirrors "buffer empty" one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_data <= 8'h00;
      buf_full <= 1'b0;
      tx_ready <= 1'b1;
    end else begin
      buf_full <= buf_full_nxt;
      tx_ready <= !buf_full_nxt;
      if (accept) begin
        buf_data <= tx_data;
      end
    end
  end

  // Frame sequencer: baud timing, bit selection and the registered serial line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
      uart_out  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          uart_out <= 1'b1;
          if (buf_full) begin
            shift_reg <= buf_data;
            state     <= START;
            uart_out  <= 1'b0;
            baud_cnt  <= '0;
            bit_idx   <= 3'd0;
          end
        end
        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            state    <= DATA;
            uart_out <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx  <= 3'd0;
`ifdef UART_TX_PARITY_EN
              state    <= PARITY;
              uart_out <= ^shift_reg;
`else
              state    <= STOP;
              uart_out <= 1'b1;
`endif
            end else begin
              bit_idx  <= bit_idx_inc;
              uart_out <= shift_reg[bit_idx_inc];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_last) begin
            baud_cnt <= '0;
            state    <= STOP;
            uart_out <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
`endif
        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            if (buf_full) begin
              shift_reg <= buf_data;
              state     <= START;
              uart_out  <= 1'b0;
            end else begin
              state    <= IDLE;
              uart_out <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          bit_idx  <= 3'd0;
          uart_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_status_transmitter.sv
// Directed bench for uart_status_transmitter with CLKS_PER_BIT=4.
// Define UART_TX_PARITY_EN for both files to exercise the parity build.
module tb_uart_status_transmitter;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int LAST = NBITS * CPB - 1;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       uart_out;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  uart_status_transmitter #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .uart_out (uart_out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the line for samples first..last of a frame; sample 0 is the first cycle after the start edge.
  task automatic check_frame(input logic [7:0] b, input int first, input int last);
    int   k;
    logic e;
    for (int i = first; i <= last; i++) begin
      if (i != first) step();
      k = i / CPB;
      if (k == 0)                e = 1'b0;
      else if (k <= 8)           e = b[k-1];
      else if (k == NBITS - 1)   e = 1'b1;
      else                       e = ^b;
      chk($sformatf("line_%02h_s%0d", b, i), {31'd0, uart_out}, {31'd0, e});
    end
  endtask

  initial begin
    rst      = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    #2 rst = 1'b1;
    #1;
    chk("rst_uart_out", {31'd0, uart_out}, 32'd1);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_busy",     {31'd0, busy},     32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Single frame 0xA5; tx_data changes after the accept must not leak in.
    tx_valid = 1'b1; tx_data = 8'hA5;
    step();
    tx_valid = 1'b0; tx_data = 8'hFF;
    chk("a5_ready_low", {31'd0, tx_ready}, 32'd0);
    chk("a5_busy",      {31'd0, busy},     32'd1);
    chk("a5_pre_line",  {31'd0, uart_out}, 32'd1);
    step();
    chk("a5_ready_back", {31'd0, tx_ready}, 32'd1);
    check_frame(8'hA5, 0, 19);
    chk("a5_busy_mid", {31'd0, busy}, 32'd1);
    step();
    check_frame(8'hA5, 20, LAST);
    step();
    chk("a5_busy_end", {31'd0, busy},     32'd0);
    chk("a5_idle",     {31'd0, uart_out}, 32'd1);

    // 0x41 then 0x42 queued during the frame: no gap between frames.
    tx_valid = 1'b1; tx_data = 8'h41;
    step();
    tx_valid = 1'b0;
    step();
    check_frame(8'h41, 0, 0);
    tx_valid = 1'b1; tx_data = 8'h42;
    step();
    tx_valid = 1'b0; tx_data = 8'h00;
    chk("q42_ready_low", {31'd0, tx_ready}, 32'd0);
    check_frame(8'h41, 1, LAST);
    step();
    check_frame(8'h42, 0, LAST);
    step();
    chk("q42_busy_end", {31'd0, busy},     32'd0);
    chk("q42_idle",     {31'd0, uart_out}, 32'd1);

    // Producer holds tx_valid for 0x01, 0x02, 0x03.
    tx_valid = 1'b1; tx_data = 8'h01;
    step();
    chk("bb_ready_after_01", {31'd0, tx_ready}, 32'd0);
    tx_data = 8'h02;
    step();
    check_frame(8'h01, 0, 0);
    chk("bb_ready_start01", {31'd0, tx_ready}, 32'd1);
    step();
    tx_data = 8'h03;
    chk("bb_ready_after_02", {31'd0, tx_ready}, 32'd0);
    check_frame(8'h01, 1, LAST);
    chk("bb_ready_full", {31'd0, tx_ready}, 32'd0);
    step();
    check_frame(8'h02, 0, 0);
    chk("bb_ready_start02", {31'd0, tx_ready}, 32'd1);
    step();
    tx_valid = 1'b0; tx_data = 8'h00;
    chk("bb_ready_after_03", {31'd0, tx_ready}, 32'd0);
    check_frame(8'h02, 1, LAST);
    step();
    check_frame(8'h03, 0, LAST);
    step();
    chk("bb_busy_end",  {31'd0, busy},     32'd0);
    chk("bb_ready_end", {31'd0, tx_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("bb_no_dup", {30'd0, uart_out, busy}, 32'd2);
    end

    // Reset during data bit 3 of 0x5A with 0x99 waiting in the buffer.
    tx_valid = 1'b1; tx_data = 8'h5A;
    step();
    tx_valid = 1'b0;
    step();
    check_frame(8'h5A, 0, 0);
    tx_valid = 1'b1; tx_data = 8'h99;
    step();
    tx_valid = 1'b0;
    check_frame(8'h5A, 1, 17);
    chk("rst_mid_ready_pre", {31'd0, tx_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_mid_line",  {31'd0, uart_out}, 32'd1);
    chk("rst_mid_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_mid_busy",  {31'd0, busy},     32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rst_discard", {30'd0, uart_out, busy}, 32'd2);
    end
    tx_valid = 1'b1; tx_data = 8'h3C;
    step();
    tx_valid = 1'b0;
    step();
    check_frame(8'h3C, 0, LAST);
    step();
    chk("3c_busy_end", {31'd0, busy}, 32'd0);

    // Reset during a start bit forces the line high at once.
    tx_valid = 1'b1; tx_data = 8'h00;
    step();
    tx_valid = 1'b0;
    step();
    chk("start_low", {31'd0, uart_out}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_start_line", {31'd0, uart_out}, 32'd1);
    step();
    rst = 1'b0;
    step();
    chk("rst_start_idle", {30'd0, uart_out, busy}, 32'd2);

`ifdef UART_TX_PARITY_EN
    // Parity frames: 0x07 has odd weight (parity 1), 0x03 even weight (parity 0).
    tx_valid = 1'b1; tx_data = 8'h07;
    step();
    tx_valid = 1'b0;
    step();
    check_frame(8'h07, 0, LAST);
    step();
    chk("p07_busy_end", {31'd0, busy}, 32'd0);
    tx_valid = 1'b1; tx_data = 8'h03;
    step();
    tx_valid = 1'b0;
    step();
    check_frame(8'h03, 0, LAST);
    step();
    chk("p03_busy_end", {31'd0, busy}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
